// File: rtl/fixed_point_issue_queue.sv
// Request queue in front of Fixed_Point_Unit: buffers tagged operations, issues them one
// at a time with stable operands, and returns each result (or a watchdog abort) with its tag.
module fixed_point_issue_queue #(
   parameter int WIDTH   = 32,
   parameter int FBITS   = 10,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic signed [WIDTH-1:0] req_operand_1,
   input  logic signed [WIDTH-1:0] req_operand_2,
   input  logic        [1:0]       req_operation,
   input  logic        [TAG_W-1:0] req_tag,
   output logic signed [WIDTH-1:0] fpu_operand_1,
   output logic signed [WIDTH-1:0] fpu_operand_2,
   output logic        [1:0]       fpu_operation,
   input  logic signed [WIDTH-1:0] fpu_result,
   input  logic                    fpu_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic signed [WIDTH-1:0] res_data,
   output logic        [TAG_W-1:0] res_tag,
   output logic                    res_timeout,
   output logic                    busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 16 || FBITS >= WIDTH) begin : g_param_check
      $error("fixed_point_issue_queue: unsupported DEPTH, TIMEOUT or FBITS");
   end

   logic signed [WIDTH-1:0] mem_op1       [DEPTH];
   logic signed [WIDTH-1:0] mem_op2       [DEPTH];
   logic        [1:0]       mem_operation [DEPTH];
   logic        [TAG_W-1:0] mem_tag       [DEPTH];

   logic [PTR_W:0]          wr_ptr;
   logic [PTR_W:0]          rd_ptr;
   logic [PTR_W-1:0]        wr_idx;
   logic [PTR_W-1:0]        rd_idx;
   logic                    full;
   logic                    empty;
   logic                    push;

   state_t                  state;
   logic signed [WIDTH-1:0] iss_op1;
   logic signed [WIDTH-1:0] iss_op2;
   logic        [1:0]       iss_operation;
   logic        [TAG_W-1:0] iss_tag;
   logic        [CNT_W-1:0] wd_cnt;

   // Pointers carry one wrap bit so full and empty are told apart without a count.
   assign wr_idx    = wr_ptr[PTR_W-1:0];
   assign rd_idx    = rd_ptr[PTR_W-1:0];
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
   assign empty     = (wr_ptr == rd_ptr);
   assign req_ready = !full;
   assign push      = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_op1[wr_idx]       <= req_operand_1;
         mem_op2[wr_idx]       <= req_operand_2;
         mem_operation[wr_idx] <= req_operation;
         mem_tag[wr_idx]       <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         state         <= IDLE;
         iss_op1       <= '0;
         iss_op2       <= '0;
         iss_operation <= '0;
         iss_tag       <= '0;
         wd_cnt        <= '0;
         res_data      <= '0;
         res_tag       <= '0;
         res_timeout   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         case (state)
            IDLE: begin
               if (!empty) begin
                  iss_op1       <= mem_op1[rd_idx];
                  iss_op2       <= mem_op2[rd_idx];
                  iss_operation <= mem_operation[rd_idx];
                  iss_tag       <= mem_tag[rd_idx];
                  rd_ptr        <= rd_ptr + (PTR_W+1)'(1);
                  state         <= ISSUE;
               end
            end
            // fpu_ready may still be left over from the previous operation, so it is not looked at here.
            ISSUE: begin
               wd_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (fpu_ready) begin
                  res_data    <= fpu_result;
                  res_tag     <= iss_tag;
                  res_timeout <= 1'b0;
                  state       <= DONE;
               end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                  res_data    <= '0;
                  res_tag     <= iss_tag;
                  res_timeout <= 1'b1;
                  state       <= DONE;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fpu_operand_1 = iss_op1;
   assign fpu_operand_2 = iss_op2;
   assign fpu_operation = iss_operation;
   assign res_valid     = (state == DONE);
   assign busy          = (state != IDLE) || !empty;

endmodule

// File: tb/tb_fixed_point_issue_queue.sv
// Directed bench for fixed_point_issue_queue with a behavioural Fixed_Point_Unit model
// whose ready timing is selectable per step (delayed, never, stale-then-delayed).
module tb_fixed_point_issue_queue;

   localparam int WIDTH   = 32;
   localparam int FBITS   = 10;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 16;

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [WIDTH-1:0]  req_operand_1;
   logic [WIDTH-1:0]  req_operand_2;
   logic [1:0]        req_operation;
   logic [TAG_W-1:0]  req_tag;
   logic [WIDTH-1:0]  fpu_operand_1;
   logic [WIDTH-1:0]  fpu_operand_2;
   logic [1:0]        fpu_operation;
   logic [WIDTH-1:0]  fpu_result;
   logic              fpu_ready;
   logic              res_valid;
   logic              res_ready;
   logic [WIDTH-1:0]  res_data;
   logic [TAG_W-1:0]  res_tag;
   logic              res_timeout;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int model_mode = 0;   // 0: ready after model_delay, 1: never ready, 2: stale ready then late ready
   int model_delay = 0;
   int mcnt = 0;

   fixed_point_issue_queue #(
      .WIDTH(WIDTH), .FBITS(FBITS), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
      .req_operation(req_operation), .req_tag(req_tag),
      .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
      .fpu_operation(fpu_operation), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout observed no_finish expected finish");
      $fatal(1);
   end

   // mcnt is 1 during the ISSUE cycle, 2 during the first WAIT cycle, and so on.
   always @(posedge clk) begin
      if (!reset || res_valid || !busy) mcnt <= 0;
      else mcnt <= mcnt + 1;
   end

   function automatic logic [31:0] model_calc(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
      logic signed [63:0] sa, sb, p;
      logic [63:0] v, r, t;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         FPU_ADD: return a + b;
         FPU_SUB: return a - b;
         FPU_MUL: begin
            p = (sa * sb) >>> FBITS;
            return p[31:0];
         end
         default: begin
            v = {32'b0, a} << FBITS;
            r = 64'd0;
            for (int i = 31; i >= 0; i--) begin
               t = r | (64'd1 << i);
               if (t * t <= v) r = t;
            end
            return r[31:0];
         end
      endcase
   endfunction

   always_comb begin
      fpu_ready  = 1'b0;
      fpu_result = model_calc(fpu_operand_1, fpu_operand_2, fpu_operation);
      case (model_mode)
         0: fpu_ready = (mcnt >= 2 + model_delay);
         2: begin
            fpu_ready = (mcnt <= 1) || (mcnt >= 6);
            if (mcnt <= 1) fpu_result = 32'hDEAD_BEEF;
         end
         default: fpu_ready = 1'b0;
      endcase
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [4:0] tag);
      int w;
      w = 0;
      req_operand_1 = a;
      req_operand_2 = b;
      req_operation = op;
      req_tag       = tag;
      req_valid     = 1'b1;
      while (!req_ready && w < 50) begin
         tick();
         w++;
      end
      if (!req_ready) chk("push_ready_timeout", req_ready, 1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_res(input int limit, output int n);
      n = 0;
      while (!res_valid && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic accept(input string name);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({name, "_drop"}, res_valid, 0);
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [4:0] tag, input int exp_n,
                         input logic [31:0] exp_data, input logic exp_to);
      int n;
      push(a, b, op, tag);
      wait_res(40, n);
      chk({name, "_latency"}, n, exp_n);
      chk({name, "_valid"}, res_valid, 1);
      chk({name, "_data"}, res_data, exp_data);
      chk({name, "_tag"}, res_tag, tag);
      chk({name, "_timeout"}, res_timeout, exp_to);
      accept(name);
   endtask

   initial begin
      int got;
      int cyc;
      reset         = 1'b0;
      req_valid     = 1'b0;
      req_operand_1 = '0;
      req_operand_2 = '0;
      req_operation = '0;
      req_tag       = '0;
      res_ready     = 1'b0;
      tick(3);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_timeout", res_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fpu", {fpu_operand_1, fpu_operand_2, fpu_operation}, 0);
      chk("rst_res", {res_data, res_tag}, 0);
      reset = 1'b1;
      tick();

      // MUL 15.75 * 4.625, unit ready 6 cycles after ISSUE
      model_mode  = 0;
      model_delay = 6;
      push(32'h0000_3F00, 32'h0000_1280, FPU_MUL, 5'd3);
      chk("mul_busy", busy, 1);
      chk("mul_idle_fpu", fpu_operand_1, 0);
      tick();
      chk("mul_issue_fpu", {fpu_operand_1, fpu_operand_2, fpu_operation},
          {32'h0000_3F00, 32'h0000_1280, FPU_MUL});
      for (int c = 2; c <= 8; c++) begin
         tick();
         chk("mul_wait_stable", {res_valid, fpu_operand_1, fpu_operand_2, fpu_operation},
             {1'b0, 32'h0000_3F00, 32'h0000_1280, FPU_MUL});
      end
      tick();
      chk("mul_valid", res_valid, 1);
      chk("mul_data", res_data, 32'h0001_2360);
      chk("mul_tag", res_tag, 3);
      chk("mul_timeout", res_timeout, 0);
      tick(2);
      chk("mul_hold", {res_valid, res_data, res_tag, res_timeout, fpu_operand_1, fpu_operation},
          {1'b1, 32'h0001_2360, 5'd3, 1'b0, 32'h0000_3F00, FPU_MUL});
      accept("mul");
      chk("mul_idle", busy, 0);

      // SQRT 99.75, unit ready 13 cycles after ISSUE
      model_delay = 13;
      run_op("sqrt", 32'h0001_8F00, 32'h0, FPU_SQRT, 5'd7, 16, 32'h0000_27F3, 1'b0);

      // Stale ready through ISSUE, low for 4 WAIT cycles, then the real result
      model_mode = 2;
      run_op("stale", 32'h0000_3F00, 32'h0000_1280, FPU_MUL, 5'd9, 7, 32'h0001_2360, 1'b0);

      // Unit never answers: abort after 16 WAIT cycles
      model_mode = 1;
      run_op("wdog", 32'h0000_1234, 32'h0000_5678, FPU_ADD, 5'd11, 18, 32'h0, 1'b1);

      // Earliest capture (ready in the first WAIT cycle) and timeout flag cleared again
      model_mode  = 0;
      model_delay = 0;
      run_op("fast", 32'h0000_0C00, 32'h0000_0400, FPU_SUB, 5'd12, 3, 32'h0000_0800, 1'b0);

      // Fill the queue while the result port is stalled
      for (int i = 0; i < 5; i++) begin
         req_operand_1 = 32'h400 * (i + 1);
         req_operand_2 = 32'h400;
         req_operation = FPU_ADD;
         req_tag       = 5'(10 + i);
         req_valid     = 1'b1;
         chk("fill_ready", req_ready, 1);
         tick();
      end
      req_tag = 5'd15;
      chk("fill_full", req_ready, 0);
      tick();
      chk("fill_full_hold", req_ready, 0);
      req_valid = 1'b0;
      res_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 6 && cyc < 60) begin
         if (res_valid) begin
            if (got < 5) chk("fill_order", res_tag, 10 + got);
            else chk("fill_extra", res_valid, 0);
            got++;
         end
         tick();
         cyc++;
      end
      res_ready = 1'b0;
      chk("fill_count", got, 5);
      chk("fill_drained", busy, 0);

      // Reset during WAIT with two entries still queued
      model_mode = 1;
      for (int i = 0; i < 3; i++) begin
         req_operand_1 = 32'h100 + i;
         req_operand_2 = 32'h200;
         req_operation = FPU_MUL;
         req_tag       = 5'(20 + i);
         req_valid     = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      tick();
      chk("rst_pre_busy", {busy, req_ready}, {1'b1, 1'b1});
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst2_req_ready", req_ready, 1);
      chk("rst2_res_valid", res_valid, 0);
      chk("rst2_res_timeout", res_timeout, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_fpu", {fpu_operand_1, fpu_operand_2, fpu_operation}, 0);
      chk("rst2_res", {res_data, res_tag}, 0);
      model_mode  = 0;
      model_delay = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst2_quiet", {res_valid, busy}, 0);
      end
      run_op("post_rst", 32'h0000_0400, 32'h0000_0400, FPU_ADD, 5'd25, 3, 32'h0000_0800, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fixed_point_issue_queue.md
# fixed_point_issue_queue

Buffers fixed-point operation requests from the execute stage and issues them one at a time to the downstream Fixed_Point_Unit. Holds operands and operation stable while the unit computes, captures its result on `ready`, and returns it with the request's tag over a valid/ready result port. Supplies the unit's stable-operand contract and tolerates its multi-cycle latency (MUL about 6 cycles, SQRT about 13). Adds a watchdog for a unit that never completes.

## Interface
- `WIDTH`, 32, operand/result width; Q(WIDTH-FBITS).FBITS two's complement, same as Fixed_Point_Unit.
- `FBITS`, 10, fractional bits; passed through only, no arithmetic in this block.
- `DEPTH`, 4, request FIFO entries; power of two, at least 2.
- `TAG_W`, 5, request tag width.
- `TIMEOUT`, 64, maximum WAIT cycles before abort; at least 16.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; equals `!full`.
- `req_operand_1` in WIDTH: first operand.
- `req_operand_2` in WIDTH: second operand; ignored by SQRT but stored.
- `req_operation` in 2: `FPU_*` encoding from Defines.vh.
- `req_tag` in TAG_W: returned unchanged with the result.
- `fpu_operand_1`, `fpu_operand_2` out WIDTH: to Fixed_Point_Unit.
- `fpu_operation` out 2: to Fixed_Point_Unit.
- `fpu_result` in WIDTH: from Fixed_Point_Unit.
- `fpu_ready` in 1: from Fixed_Point_Unit.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts.
- `res_data` out WIDTH: captured result.
- `res_tag` out TAG_W: tag of the completed request.
- `res_timeout` out 1: result aborted by the watchdog; `res_data` is 0 in that case.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.

## Operation
- FIFO
  - Circular buffer with read/write pointers that are log2(DEPTH)+1 bits wide.
  - full: pointers differ only in the MSB. empty: pointers are equal.
  - Write when `req_valid && req_ready`; pop on the IDLE→ISSUE transition.
  - Simultaneous write and pop when full: the write is refused because `req_ready` is low. Count is unchanged.
  - Simultaneous write and pop when empty: impossible, since the pop requires non-empty. The entry written becomes visible the next cycle.
- FSM states
  - IDLE
    - Not empty: pop head into the issue register (operands, operation, tag); go to ISSUE.
    - Empty: stay.
  - ISSUE
    - One cycle. `fpu_*` already show the new operands.
    - `fpu_ready` is ignored here, because it may be stale from the previous operation.
    - Clear the watchdog counter; go to WAIT.
  - WAIT
    - Watchdog counter increments each cycle.
    - `fpu_ready`=1: latch `fpu_result` into `res_data`, set `res_timeout`=0, go to DONE.
    - Else, counter reaches TIMEOUT-1: set `res_data`=0, `res_timeout`=1, go to DONE.
    - If both happen in the same cycle, `fpu_ready` wins.
  - DONE
    - `res_valid`=1.
    - On `res_ready`: go to IDLE, and `res_valid` drops next cycle.
    - `res_data`, `res_tag` and `res_timeout` hold stable until accepted.
- `fpu_operand_*` and `fpu_operation` are driven from the issue register. They change only on the IDLE→ISSUE edge and stay stable through ISSUE, WAIT and DONE.
- Invalid operation codes are issued unchanged. The watchdog covers a unit that never completes.

## Timing
- Reset values, all forced in the cycle `reset`=0 is sampled:
  - FIFO pointers 0; FSM IDLE; issue register 0; `res_data`, `res_tag` 0; watchdog counter 0.
  - Outputs: `req_ready`=1, `res_valid`=0, `res_timeout`=0, `busy`=0, `fpu_*`=0.
- Reset mid-operation discards FIFO contents and the in-flight request. No result is produced for either.
- Write accepted at edge N, FIFO previously empty and FSM IDLE:
  - Pop at N+1; ISSUE during N+1..N+2; WAIT from N+2.
  - Earliest capture at edge N+3, with `res_valid` high from N+3.
- Latency from request accept to `res_valid` is 3 plus the unit's ready delay, measured in cycles after ISSUE.
- Back-to-back: the next pop happens at the edge after the `res_ready` handshake. There is no issue overlap.
- `req_ready` is combinational from the pointers only, never from `req_valid`.

## Test plan
- MUL, using a Fixed_Point_Unit model with ready after 6 cycles:
  - Stimulus: `req_operand_1`=0x00003F00 (15.75), `req_operand_2`=0x00001280 (4.625), tag 3.
  - Required: `res_data`=0x00012360 (72.84375), `res_tag`=3, `res_timeout`=0.
  - Required: `fpu_*` stable throughout ISSUE and WAIT.
- SQRT:
  - Stimulus: operand_1=0x00018F00 (99.75), operand_2=0, tag 7.
  - Required: `res_data`=0x000027F3, `res_tag`=7.
- FIFO fill:
  - Stimulus: hold `res_ready`=0 and push 5 requests.
  - Required: `req_ready`=0 once the queue is full, i.e. after 4 accepts, or 5 if one entry has already popped.
  - Required: release `res_ready`, and tags return in FIFO order with none lost or duplicated.
- Stale ready:
  - Stimulus: the model holds `fpu_ready`=1 through ISSUE, then drops it for 4 cycles.
  - Required: capture occurs only on the later ready, not the stale one.
- Watchdog:
  - Stimulus: `fpu_ready` tied low, TIMEOUT=16.
  - Required: `res_valid` asserts exactly 16 WAIT cycles after ISSUE, with `res_data`=0 and `res_timeout`=1.
- Reset:
  - Stimulus: assert `reset`=0 during WAIT with 2 entries queued.
  - Required: the next cycle shows every output at its reset value.
  - Required: no result appears until a new request is pushed.
